// File: rtl/run_controller.sv
// Run/dump sequencer: clears the register file, runs the core for a bounded
// number of cycles (or until halt), then streams every register out.
module run_controller #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned RUN_CYCLES = 1600,
  parameter bit          CLEAR_EN   = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  core_halt,
  output logic                  core_reset,
  output logic                  rf_wr_en,
  output logic [ADDR_WIDTH-1:0] rf_wr_addr,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  output logic [ADDR_WIDTH-1:0] rf_rd_addr,
  input  logic [DATA_WIDTH-1:0] rf_rd_data,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [ADDR_WIDTH-1:0] dump_addr,
  output logic [DATA_WIDTH-1:0] dump_data,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic [CNT_WIDTH-1:0]  cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DUMP,
    S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [CNT_WIDTH-1:0]  LAST_CNT = CNT_WIDTH'(RUN_CYCLES - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  timeout_q, timeout_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    timeout_d  = timeout_q;
    core_reset = 1'b1;
    rf_wr_en   = 1'b0;
    dump_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        done = (state_q == S_DONE);
        if (start) begin
          if (CLEAR_EN) begin
            state_d = S_CLEAR;
            idx_d   = '0;
          end else begin
            state_d   = S_RUN;
            cnt_d     = '0;
            timeout_d = 1'b0;
          end
        end
      end

      S_CLEAR: begin
        busy     = 1'b1;
        rf_wr_en = 1'b1;
        idx_d    = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d   = S_RUN;
          idx_d     = '0;
          cnt_d     = '0;
          timeout_d = 1'b0;
        end
      end

      S_RUN: begin
        busy       = 1'b1;
        core_reset = 1'b0;
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        // Halt wins over the limit when both land on the same cycle.
        if (core_halt || (cnt_q == LAST_CNT)) begin
          state_d   = S_DUMP;
          idx_d     = '0;
          timeout_d = !core_halt;
        end
      end

      S_DUMP: begin
        busy       = 1'b1;
        dump_valid = 1'b1;
        if (dump_ready) begin
          if (idx_q == LAST_IDX) state_d = S_DONE;
          else                   idx_d   = idx_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign rf_wr_addr  = idx_q;
  assign rf_wr_data  = '0;
  assign rf_rd_addr  = idx_q;
  assign dump_addr   = idx_q;
  assign dump_data   = rf_rd_data;
  assign timeout     = timeout_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_run_controller.sv
// Scoreboard bench for run_controller: a behavioural register file and core
// model predict clear writes, run length, timeout and the dumped contents.
module tb_run_controller;
  localparam int unsigned DW  = 32;
  localparam int unsigned NR  = 32;
  localparam int unsigned AW  = 5;
  localparam int unsigned CW  = 32;
  localparam int unsigned RC  = 1600;
  localparam int unsigned RC2 = 10;

  logic clock;
  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset, start, core_halt, dump_ready;
  logic          core_reset, rf_wr_en, dump_valid, busy, done, timeout;
  logic [AW-1:0] rf_wr_addr, rf_rd_addr, dump_addr;
  logic [DW-1:0] rf_wr_data, rf_rd_data, dump_data;
  logic [CW-1:0] cycle_count;

  run_controller #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW), .CNT_WIDTH(CW),
                   .RUN_CYCLES(RC), .CLEAR_EN(1'b1)) dut (
    .clock(clock), .reset(reset), .start(start), .core_halt(core_halt),
    .core_reset(core_reset), .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr),
    .rf_wr_data(rf_wr_data), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr),
    .dump_data(dump_data), .busy(busy), .done(done), .timeout(timeout),
    .cycle_count(cycle_count));

  // Second instance: no clear phase, short run limit.
  logic          b_start, b_halt, b_dump_ready;
  logic          b_core_reset, b_rf_wr_en, b_dump_valid, b_busy, b_done, b_timeout;
  logic [AW-1:0] b_rf_wr_addr, b_rf_rd_addr, b_dump_addr;
  logic [DW-1:0] b_rf_wr_data, b_rd_data, b_dump_data;
  logic [CW-1:0] b_cycle_count;

  run_controller #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW), .CNT_WIDTH(CW),
                   .RUN_CYCLES(RC2), .CLEAR_EN(1'b0)) dut2 (
    .clock(clock), .reset(reset), .start(b_start), .core_halt(b_halt),
    .core_reset(b_core_reset), .rf_wr_en(b_rf_wr_en), .rf_wr_addr(b_rf_wr_addr),
    .rf_wr_data(b_rf_wr_data), .rf_rd_addr(b_rf_rd_addr), .rf_rd_data(b_rd_data),
    .dump_valid(b_dump_valid), .dump_ready(b_dump_ready), .dump_addr(b_dump_addr),
    .dump_data(b_dump_data), .busy(b_busy), .done(b_done), .timeout(b_timeout),
    .cycle_count(b_cycle_count));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got no event within bound, required the event", name);
  endtask

  // Register file and a scripted core that writes cw_data[k] to cw_addr[k] on its k-th cycle.
  logic [DW-1:0] rf [NR];
  logic [AW-1:0] cw_addr [RC+2];
  logic [DW-1:0] cw_data [RC+2];
  int            run_seen = 0;
  int            halt_at  = 0;
  logic          arm;

  assign rf_rd_data = rf[rf_rd_addr];
  assign core_halt  = (run_seen + 1 == halt_at);

  always @(posedge clock) begin
    if (arm) begin
      run_seen <= 0;
      for (int i = 0; i < NR; i++) rf[i] <= 32'hDEADBEEF;
    end else begin
      if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;
      if (!core_reset) begin
        if (cw_addr[run_seen+1] != '0) rf[cw_addr[run_seen+1]] <= cw_data[run_seen+1];
        run_seen <= run_seen + 1;
      end
    end
  end

  int rdy_mode = 0;
  initial begin
    int phase;
    phase = 0;
    dump_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (rdy_mode)
        1:       dump_ready = (phase % 4 == 3);
        2:       dump_ready = 1'($urandom_range(0, 1));
        default: dump_ready = 1'b1;
      endcase
      phase++;
    end
  end

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } dump_t;
  typedef struct { int cnt; bit to; } res_t;
  int    wr_q[$];
  dump_t dump_q[$];
  res_t  res_q[$];
  bit    sb_en = 0;
  logic  done_q = 1'b0;
  logic  hold_v = 1'b0;
  logic [AW-1:0] hold_a;
  logic [DW-1:0] hold_d;

  always @(negedge clock) begin
    int    ea;
    dump_t ed;
    res_t  er;
    if (reset && sb_en) begin
      if (rf_wr_en) begin
        if (wr_q.size() == 0) miss("wr_expected");
        else begin
          ea = wr_q.pop_front();
          check("wr_addr", 64'(rf_wr_addr), 64'(ea));
          check("wr_data", 64'(rf_wr_data), 64'd0);
        end
      end
      if (hold_v) begin
        check("hold_valid", 64'(dump_valid), 64'd1);
        check("hold_addr", 64'(dump_addr), 64'(hold_a));
        check("hold_data", 64'(dump_data), 64'(hold_d));
      end
      if (dump_valid && dump_ready) begin
        if (dump_q.size() == 0) miss("dump_expected");
        else begin
          ed = dump_q.pop_front();
          check("dump_addr", 64'(dump_addr), 64'(ed.a));
          check("dump_data", 64'(dump_data), 64'(ed.d));
        end
      end
      if (done && !done_q) begin
        if (res_q.size() == 0) miss("result_expected");
        else begin
          er = res_q.pop_front();
          check("cycle_count", 64'(cycle_count), 64'(er.cnt));
          check("timeout", 64'(timeout), 64'(er.to));
          check("core_run_cycles", 64'(run_seen), 64'(er.cnt));
        end
      end
    end
    hold_v <= dump_valid && !dump_ready;
    hold_a <= dump_addr;
    hold_d <= dump_data;
    done_q <= done;
  end

  int b_xfers = 0;
  int b_wrs   = 0;
  always @(negedge clock) begin
    if (b_dump_valid && b_dump_ready) b_xfers <= b_xfers + 1;
    if (b_rf_wr_en) b_wrs <= b_wrs + 1;
  end

  // h: core cycle on which halt is raised (0 = never); mode: dump_ready pattern.
  task automatic run_seq(input int h, input int mode, input bit inj);
    logic [DW-1:0] model [NR];
    bit in_lim, fin;
    int explen;
    in_lim = (h >= 1) && (h <= int'(RC));
    explen = in_lim ? h : int'(RC);
    for (int k = 1; k <= int'(RC); k++) begin
      cw_addr[k] = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(1, NR - 1)) : '0;
      cw_data[k] = $urandom;
    end
    for (int i = 0; i < NR; i++) model[i] = '0;
    for (int k = 1; k <= explen; k++)
      if (cw_addr[k] != '0) model[cw_addr[k]] = cw_data[k];
    for (int i = 0; i < NR; i++) begin
      wr_q.push_back(i);
      dump_q.push_back('{a: AW'(i), d: model[i]});
    end
    res_q.push_back('{cnt: explen, to: !in_lim});
    halt_at  = h;
    rdy_mode = mode;
    @(negedge clock); start = 1'b1; arm = 1'b1;
    @(negedge clock); start = 1'b0; arm = 1'b0;
    check("start_busy", 64'(busy), 64'd1);
    check("start_done_low", 64'(done), 64'd0);
    fin = 0;
    for (int cyc = 0; cyc < int'(RC + NR * 8 + 200) && !fin; cyc++) begin
      @(negedge clock);
      start = inj && (explen > 10) && (cyc == int'(NR) + 5 || cyc == int'(NR) + explen + 3);
      if (done) fin = 1;
    end
    start = 1'b0;
    if (!fin) miss("done_wait");
    repeat (2) @(negedge clock);
    check("wr_q_drained", 64'(wr_q.size()), 64'd0);
    check("dump_q_drained", 64'(dump_q.size()), 64'd0);
    check("res_q_drained", 64'(res_q.size()), 64'd0);
  endtask

  task automatic run_b();
    int x0;
    bit fin;
    x0 = b_xfers;
    @(negedge clock); b_start = 1'b1;
    @(negedge clock); b_start = 1'b0;
    check("b_direct_run", 64'(b_core_reset), 64'd0);
    check("b_done_low", 64'(b_done), 64'd0);
    fin = 0;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      @(negedge clock);
      b_start = (cyc == 3) || (cyc == 20);
      if (b_done) fin = 1;
    end
    b_start = 1'b0;
    if (!fin) miss("b_done_wait");
    repeat (2) @(negedge clock);
    check("b_cycle_count", 64'(b_cycle_count), 64'(RC2));
    check("b_timeout", 64'(b_timeout), 64'd1);
    check("b_transfers", 64'(b_xfers - x0), 64'(NR));
  endtask

  initial begin
    bit seen;
    reset = 1'b0; start = 1'b0; arm = 1'b0;
    b_start = 1'b0; b_halt = 1'b0; b_dump_ready = 1'b1; b_rd_data = '0;
    for (int k = 0; k < int'(RC) + 2; k++) begin
      cw_addr[k] = '0;
      cw_data[k] = '0;
    end
    repeat (3) @(negedge clock);
    check("rst_core_reset", 64'(core_reset), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dump_valid", 64'(dump_valid), 64'd0);
    check("rst_rf_wr_en", 64'(rf_wr_en), 64'd0);
    check("rst_cycle_count", 64'(cycle_count), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    check("rst_b_core_reset", 64'(b_core_reset), 64'd1);
    reset = 1'b1;
    @(negedge clock);

    // Reset asserted partway through a run.
    @(negedge clock); start = 1'b1; arm = 1'b1;
    @(negedge clock); start = 1'b0; arm = 1'b0;
    seen = 0;
    for (int cyc = 0; cyc < 2000 && !seen; cyc++) begin
      @(negedge clock);
      if (run_seen >= 500) seen = 1;
    end
    if (!seen) miss("midrun_wait");
    reset = 1'b0;
    @(negedge clock);
    check("midrst_core_reset", 64'(core_reset), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_cycle_count", 64'(cycle_count), 64'd0);
    check("midrst_timeout", 64'(timeout), 64'd0);
    check("midrst_dump_valid", 64'(dump_valid), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("post_rst_idle_busy", 64'(busy), 64'd0);
    check("post_rst_idle_core", 64'(core_reset), 64'd1);

    sb_en = 1;
    run_seq(0, 0, 0);
    run_seq(200, 1, 1);
    run_seq(int'(RC), 2, 1);
    run_seq(int'(RC) + 1, 0, 0);
    run_seq(1, 0, 0);
    for (int n = 0; n < 4; n++)
      run_seq(int'($urandom_range(1, RC + 50)), int'($urandom_range(0, 2)), 1);

    run_b();
    run_b();
    check("b_no_rf_writes", 64'(b_wrs), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
